// File: rtl/scroll_pkg.sv
// -----------------------------------------------------------------------------
// scroll_pkg
// Shared definitions for the scrolling frame-buffer address generator:
//   - dir_e        : scroll direction encodings (up/down/left/right)
//   - IMG_W_DEF    : default image width  (320)
//   - IMG_H_DEF    : default image height (240)
//   - clog2()      : ceiling log2, never below 1, used to size offsets/counters
// -----------------------------------------------------------------------------
package scroll_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;

  // Minimum of 1 so that a modulo-1 counter still has a legal vector width.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    if (r < 1) begin
      r = 1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Up/down modulo-N counter with hold. One instance per scroll axis.
// Ports:
//   clk  in  1  clock
//   rst  in  1  asynchronous, active-high reset (count -> 0)
//   inc  in  1  count up, N-1 wraps to 0 (takes priority over dec)
//   dec  in  1  count down, 0 wraps to N-1
//   cnt  out W  current count (registered)
// -----------------------------------------------------------------------------
module wrap_counter #(
  parameter int N = 320,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: increment/decrement with wrap at the modulus, else hold.
  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      if (cnt_q == W'(N - 1)) begin
        cnt_d = {W{1'b0}};
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else if (dec) begin
      if (cnt_q == {W{1'b0}}) begin
        cnt_d = W'(N - 1);
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/scroll_addr_gen.sv
// -----------------------------------------------------------------------------
// scroll_addr_gen
// Maps VGA timing counters onto a down-scaled IMG_W x IMG_H frame buffer with
// two-axis wrap-around scrolling. One registered cycle of address latency.
// Optional feature macro: SCROLL_MIRROR_EN (adds 'mirror' input, horizontal flip).
// Ports:
//   clk        in  1       pixel/system clock
//   rst        in  1       asynchronous, active-high reset
//   en         in  1       scroll enable; 0 freezes offsets and prescaler
//   tick       in  1       one-cycle scroll strobe
//   dir        in  2       0 up, 1 down, 2 left, 3 right
//   h_cnt      in  10      horizontal pixel counter
//   v_cnt      in  10      vertical pixel counter
//   mirror     in  1       (SCROLL_MIRROR_EN only) horizontal flip
//   pixel_addr out ADDR_W  registered memory address
//   in_img     out 1       registered; scaled coordinate lies inside image
//   x_off      out clog2(IMG_W)  horizontal offset
//   y_off      out clog2(IMG_H)  vertical offset
// -----------------------------------------------------------------------------
module scroll_addr_gen
  import scroll_pkg::*;
#(
  parameter int IMG_W       = IMG_W_DEF,
  parameter int IMG_H       = IMG_H_DEF,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 17,
  parameter int STEP_DIV    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      tick,
  input  logic [1:0]                dir,
  input  logic [9:0]                h_cnt,
  input  logic [9:0]                v_cnt,
`ifdef SCROLL_MIRROR_EN
  input  logic                      mirror,
`endif
  output logic [ADDR_W-1:0]         pixel_addr,
  output logic                      in_img,
  output logic [clog2(IMG_W)-1:0]   x_off,
  output logic [clog2(IMG_H)-1:0]   y_off
);

  localparam int XW = clog2(IMG_W);
  localparam int YW = clog2(IMG_H);
  localparam int PW = clog2(STEP_DIV);

  logic [PW-1:0]     pre_q;
  logic [PW-1:0]     pre_d;
  logic              step;
  logic              x_inc;
  logic              x_dec;
  logic              y_inc;
  logic              y_dec;

  logic [9:0]        sx;
  logic [9:0]        sy;
  logic              in_img_n;
  logic [XW:0]       col_sum;
  logic [YW:0]       row_sum;
  logic [XW-1:0]     col;
  logic [YW-1:0]     row;
  logic [ADDR_W-1:0] pixel_addr_d;
  logic [ADDR_W-1:0] pixel_addr_q;
  logic              in_img_q;

  // Prescaler: advances only on enabled ticks; the wrap cycle issues a step.
  always_comb begin
    pre_d = pre_q;
    step  = 1'b0;
    if (tick && en) begin
      if (pre_q == PW'(STEP_DIV - 1)) begin
        pre_d = {PW{1'b0}};
        step  = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
        step  = 1'b0;
      end
    end else begin
      pre_d = pre_q;
      step  = 1'b0;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= {PW{1'b0}};
    end else begin
      pre_q <= pre_d;
    end
  end

  // Direction decode. Left scroll moves the window right in memory, so x grows.
  always_comb begin
    x_inc = 1'b0;
    x_dec = 1'b0;
    y_inc = 1'b0;
    y_dec = 1'b0;
    if (step) begin
      case (dir)
        DIR_UP:    y_dec = 1'b1;
        DIR_DOWN:  y_inc = 1'b1;
        DIR_LEFT:  x_inc = 1'b1;
        DIR_RIGHT: x_dec = 1'b1;
        default: begin
          x_inc = 1'b0;
          y_inc = 1'b0;
        end
      endcase
    end else begin
      x_inc = 1'b0;
    end
  end

  wrap_counter #(.N(IMG_W), .W(XW)) u_x_cnt (
    .clk (clk),
    .rst (rst),
    .inc (x_inc),
    .dec (x_dec),
    .cnt (x_off)
  );

  wrap_counter #(.N(IMG_H), .W(YW)) u_y_cnt (
    .clk (clk),
    .rst (rst),
    .inc (y_inc),
    .dec (y_dec),
    .cnt (y_off)
  );

  // Address path. Both addends are below the modulus when in_img_n is set,
  // so one conditional subtract completes the wrap; outside the image the
  // column/row values are don't-care because the address is forced to 0.
  always_comb begin
    sx       = h_cnt >> SCALE_SHIFT;
    sy       = v_cnt >> SCALE_SHIFT;
    in_img_n = (32'(sx) < 32'(IMG_W)) && (32'(sy) < 32'(IMG_H));
    col_sum  = (XW+1)'(sx) + (XW+1)'(x_off);
    row_sum  = (YW+1)'(sy) + (YW+1)'(y_off);
    if (col_sum >= (XW+1)'(IMG_W)) begin
      col_sum = col_sum - (XW+1)'(IMG_W);
    end else begin
      col_sum = col_sum;
    end
    if (row_sum >= (YW+1)'(IMG_H)) begin
      row_sum = row_sum - (YW+1)'(IMG_H);
    end else begin
      row_sum = row_sum;
    end
    col = col_sum[XW-1:0];
    row = row_sum[YW-1:0];
`ifdef SCROLL_MIRROR_EN
    if (mirror) begin
      col = XW'(IMG_W - 1) - col;
    end else begin
      col = col;
    end
`endif
    if (in_img_n) begin
      pixel_addr_d = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
    end else begin
      pixel_addr_d = {ADDR_W{1'b0}};
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_addr_q <= {ADDR_W{1'b0}};
      in_img_q     <= 1'b0;
    end else begin
      pixel_addr_q <= pixel_addr_d;
      in_img_q     <= in_img_n;
    end
  end

  assign pixel_addr = pixel_addr_q;
  assign in_img     = in_img_q;

endmodule

// File: tb/tb_scroll_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_scroll_addr_gen
// Directed bench: dut1 uses STEP_DIV=1, dut4 uses STEP_DIV=4 for prescaler
// behaviour. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_scroll_addr_gen;

  logic        clk;
  logic        rst;
  logic        en1, tick1;
  logic [1:0]  dir1;
  logic [9:0]  h1, v1;
  logic        en4, tick4;
  logic [1:0]  dir4;
  logic [9:0]  h4, v4;
  logic        mirror;
  logic [16:0] addr1, addr4;
  logic        in1, in4;
  logic [8:0]  x1, x4;
  logic [7:0]  y1, y4;

  int pass_cnt = 0;
  int total    = 0;

  scroll_addr_gen #(.IMG_W(320), .IMG_H(240), .SCALE_SHIFT(1), .ADDR_W(17), .STEP_DIV(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .en         (en1),
    .tick       (tick1),
    .dir        (dir1),
    .h_cnt      (h1),
    .v_cnt      (v1),
`ifdef SCROLL_MIRROR_EN
    .mirror     (mirror),
`endif
    .pixel_addr (addr1),
    .in_img     (in1),
    .x_off      (x1),
    .y_off      (y1)
  );

  scroll_addr_gen #(.IMG_W(320), .IMG_H(240), .SCALE_SHIFT(1), .ADDR_W(17), .STEP_DIV(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .en         (en4),
    .tick       (tick4),
    .dir        (dir4),
    .h_cnt      (h4),
    .v_cnt      (v4),
`ifdef SCROLL_MIRROR_EN
    .mirror     (1'b0),
`endif
    .pixel_addr (addr4),
    .in_img     (in4),
    .x_off      (x4),
    .y_off      (y4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks1(input int n);
    tick1 = 1'b1;
    repeat (n) cyc();
    tick1 = 1'b0;
  endtask

  task automatic ticks4(input int n);
    tick4 = 1'b1;
    repeat (n) cyc();
    tick4 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en1 = 1'b0; tick1 = 1'b0; dir1 = 2'd0; h1 = 10'd0; v1 = 10'd0;
    en4 = 1'b0; tick4 = 1'b0; dir4 = 2'd1; h4 = 10'd0; v4 = 10'd0; mirror = 1'b0;
    #1;
    check("rst_addr", 32'(addr1), 32'd0);
    check("rst_in_img", 32'(in1), 32'd0);
    check("rst_x", 32'(x1), 32'd0);
    check("rst_y", 32'(y1), 32'd0);
    check("rst_addr4", 32'(addr4), 32'd0);
    cyc();
    rst = 1'b0;

    // Origin and far corner with zero offsets.
    cyc();
    check("origin_addr", 32'(addr1), 32'd0);
    check("origin_in_img", 32'(in1), 32'd1);
    check("origin_in_img4", 32'(in4), 32'd1);
    h1 = 10'd639; v1 = 10'd479;
    cyc();
    check("corner_addr", 32'(addr1), 32'd76799);

    // Up step: same-edge address still uses pre-step offset.
    en1 = 1'b1; dir1 = 2'd0; h1 = 10'd0; v1 = 10'd0;
    ticks1(1);
    check("up_y", 32'(y1), 32'd239);
    check("up_same_cycle_addr", 32'(addr1), 32'd0);
    cyc();
    check("up_addr", 32'(addr1), 32'd76480);
    ticks1(1);
    check("up2_y", 32'(y1), 32'd238);

    // Down wraps 239 -> 0.
    dir1 = 2'd1;
    ticks1(2);
    check("down_wrap_y", 32'(y1), 32'd0);

    // Left: full revolution, then offset 5.
    dir1 = 2'd2;
    ticks1(320);
    check("left_rev_x", 32'(x1), 32'd0);
    check("left_rev_y", 32'(y1), 32'd0);
    ticks1(5);
    check("left5_x", 32'(x1), 32'd5);
    h1 = 10'd636; v1 = 10'd0;
    cyc();
    check("col_wrap_addr", 32'(addr1), 32'd3);

    // Right wraps 0 -> 319.
    dir1 = 2'd3;
    ticks1(6);
    check("right_wrap_x", 32'(x1), 32'd319);
    h1 = 10'd0; v1 = 10'd0;
    cyc();
    check("right_addr", 32'(addr1), 32'd319);

    // en=0 freezes offsets.
    en1 = 1'b0; dir1 = 2'd2;
    ticks1(3);
    check("en0_x", 32'(x1), 32'd319);

    // Outside the image.
    h1 = 10'd640; v1 = 10'd0;
    cyc();
    check("h640_in_img", 32'(in1), 32'd0);
    check("h640_addr", 32'(addr1), 32'd0);
    h1 = 10'd0; v1 = 10'd480;
    cyc();
    check("v480_in_img", 32'(in1), 32'd0);
    // x=319,y=0: col = 319+319-320 = 318, row 239.
    h1 = 10'd639; v1 = 10'd479;
    cyc();
    check("corner_wrap_addr", 32'(addr1), 32'd76798);

    // Mid-frame async reset.
    en1 = 1'b1; dir1 = 2'd1;
    ticks1(100);
    check("down100_y", 32'(y1), 32'd100);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_y", 32'(y1), 32'd0);
    check("midrst_x", 32'(x1), 32'd0);
    check("midrst_addr", 32'(addr1), 32'd0);
    check("midrst_in_img", 32'(in1), 32'd0);
    #1;
    rst = 1'b0; en1 = 1'b0; h1 = 10'd2; v1 = 10'd2;
    cyc();
    check("post_rst_addr", 32'(addr1), 32'd321);
    check("post_rst_in_img", 32'(in1), 32'd1);

    // STEP_DIV=4 prescaler.
    en4 = 1'b1; dir4 = 2'd1;
    ticks4(3);
    check("div4_3ticks_y", 32'(y4), 32'd0);
    en4 = 1'b0;
    ticks4(2);
    check("div4_en0_y", 32'(y4), 32'd0);
    en4 = 1'b1;
    ticks4(1);
    check("div4_4th_y", 32'(y4), 32'd1);
    ticks4(2);
    dir4 = 2'd0;
    ticks4(1);
    check("div4_dirchg_hold_y", 32'(y4), 32'd1);
    ticks4(1);
    check("div4_dirchg_step_y", 32'(y4), 32'd0);

`ifdef SCROLL_MIRROR_EN
    h1 = 10'd0; v1 = 10'd0; mirror = 1'b1;
    cyc();
    check("mirror_addr", 32'(addr1), 32'd319);
    mirror = 1'b0;
    #2;
    check("mirror_hold_addr", 32'(addr1), 32'd319);
    cyc();
    check("unmirror_addr", 32'(addr1), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
